dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-requester arbiter and sequencer for the single-port 256×32 data RAM. It shares the RAM between the CPU writeback/load stage and an external requester (program loader / debug port). Each access uses a request/grant/read-valid handshake, and the block drives the RAM enable, write-enable, address and data. The CPU receives a stall while its own request is pending, so the pipeline holds its stage-5 access until the request is served.

## Interface
Parameters:
- AW, 8, RAM address width
- DW, 32, RAM data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until completion
- cpu_we  in  1  CPU write (1) / read (0); stable while cpu_req
- cpu_addr  in  AW  CPU address; stable while cpu_req
- cpu_wdata  in  DW  CPU write data; stable while cpu_req
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_stall  out  1  cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid (combinational)
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/AW/DW  external-side equivalents
- ext_lock  in  1  while high, the external side retains exclusive ownership
- ext_gnt, ext_rvalid  out  1  external-side equivalents
- rdata  out  DW  read data, shared; qualified by cpu_rvalid / ext_rvalid
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; synchronous, 1-cycle latency

## Operation
- States: IDLE, GNT_CPU, GNT_EXT, RD_WAIT. Registered: state, owner bit, pending-read bit, priority pointer, lock_hold.
- IDLE: arbitrate registered request inputs.
  - Only one requester active: grant it.
  - Both active: grant by priority (see Configuration).
  - lock_hold=1: CPU is never granted; only ext_req is considered.
- GNT_x (one cycle):
  - ram_en=1; ram_we, ram_addr, ram_din copied from the owner's inputs; x_gnt=1.
  - Write: next state IDLE.
  - Read: next state RD_WAIT.
  - On GNT_EXT, lock_hold <= ext_lock.
- RD_WAIT (one cycle):
  - rdata = ram_dout; owner's rvalid=1; next state IDLE.
- lock_hold clears in IDLE when ext_lock=0. A lock asserted with no ext_req pending does not block the CPU; lock_hold is only set at an ext grant.
- A requester must drop or renew its request in the cycle after gnt (write) or rvalid (read). The arbiter passes through IDLE after every access, so a held request is never double-served within one access.
- Outside GNT states: ram_en=0, ram_we=0, ram_addr=0, ram_din=0.

## Timing
- Reset (asynchronous, on reset=0): state=IDLE, lock_hold=0, priority pointer=CPU, and every output 0 (gnt, rvalid, rdata, ram_*). cpu_stall equals cpu_req while held in reset.
- Write latency: request seen in IDLE at cycle N; GNT at N+1; IDLE at N+2. Sustained throughput: 1 write per 2 cycles.
- Read latency: GNT at N+1, rvalid at N+2. Sustained throughput: 1 read per 3 cycles.
- Request arriving during GNT/RD_WAIT: waits; arbitrated at the next IDLE.
- Reset asserted mid-read: the pending read is dropped and no rvalid is issued; a write already issued in GNT is not retracted.
- Address wrap: none. Addresses pass through unmodified (0xFF is valid).

## Configuration
- DRAM_ARB_RR_EN defined: round-robin on contention.
  - Pointer toggles to the non-granted side after every contended grant.
  - Uncontended grants leave the pointer unchanged.
- DRAM_ARB_RR_EN undefined: fixed priority, with the CPU always winning contention. The pointer register is not instantiated.
- ext_lock behaviour is identical in both builds.

## Test plan
- Reset, then cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF: cpu_gnt is high at cycle 2, with ram_we=1, ram_addr=0x10, ram_din=0xDEADBEEF; cpu_stall drops at cycle 2.
- CPU read of addr 0x10 after that write: cpu_rvalid is high exactly 2 cycles after the request is sampled; rdata=0xDEADBEEF; ext_rvalid stays 0.
- Both sides request reads simultaneously, repeatedly:
  - Fixed build: CPU granted every time, ext starves.
  - RR build: grants alternate CPU, EXT, CPU, EXT.
- ext_lock=1 with ext writes to 0x00..0x03 back-to-back while cpu_req=1: all four ext grants occur before any cpu_gnt, and cpu_stall stays 1 throughout; after ext_lock=0, cpu_gnt follows at the next IDLE.
- Pull reset low during RD_WAIT of an ext read: no ext_rvalid, all outputs 0, state IDLE. After release, a held cpu_req is granted 2 cycles later.
- Write to addr 0xFF with wdata 0xFFFFFFFF, then read it back: rdata=0xFFFFFFFF, with no address wrap or truncation.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Request/grant/read-valid bundle between the two requesters, the arbiter and the data RAM.
// slave = arbiter side; master = requesters plus the RAM read port.
interface dram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic          cpu_stall;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_lock;
  logic          ext_gnt;
  logic          ext_rvalid;

  logic [DW-1:0] rdata;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  ram_dout,
    output cpu_gnt, cpu_rvalid, cpu_stall,
    output ext_gnt, ext_rvalid,
    output rdata,
    output ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output ram_dout,
    input  cpu_gnt, cpu_rvalid, cpu_stall,
    input  ext_gnt, ext_rvalid,
    input  rdata,
    input  ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM (CPU vs. external loader/debug).
// Define DRAM_ARB_RR_EN for round-robin on contention; otherwise the CPU wins every contention.
module dram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           reset,
  dram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_EXT, RD_WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t state, state_n;
  logic   owner, owner_n;     // 1 = external side owns the current access
  logic   pend, pend_n;
  logic   lock_hold, lock_n;
  logic   cpu_ok, contend, sel_ext;
  logic   in_gnt, rd_done;
  req_t   cur;

`ifdef DRAM_ARB_RR_EN
  logic   prio, prio_n;       // 1 = external side preferred on next contention
`endif

  // A held lock shuts the CPU out of arbitration entirely.
  assign cpu_ok  = bus.cpu_req & ~lock_hold;
  assign contend = cpu_ok & bus.ext_req;

`ifdef DRAM_ARB_RR_EN
  assign sel_ext = contend ? prio : (bus.ext_req & ~cpu_ok);
`else
  assign sel_ext = bus.ext_req & ~cpu_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      pend      <= 1'b0;
      lock_hold <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      prio      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      pend      <= pend_n;
      lock_hold <= lock_n;
`ifdef DRAM_ARB_RR_EN
      prio      <= prio_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    pend_n  = pend;
    lock_n  = lock_hold;
`ifdef DRAM_ARB_RR_EN
    prio_n  = prio;
`endif
    case (state)
      IDLE: begin
        if (!bus.ext_lock) lock_n = 1'b0;
        if (cpu_ok || bus.ext_req) begin
          owner_n = sel_ext;
          state_n = sel_ext ? GNT_EXT : GNT_CPU;
`ifdef DRAM_ARB_RR_EN
          if (contend) prio_n = ~prio;
`endif
        end
      end
      GNT_CPU: begin
        pend_n  = ~bus.cpu_we;
        state_n = bus.cpu_we ? IDLE : RD_WAIT;
      end
      GNT_EXT: begin
        pend_n  = ~bus.ext_we;
        lock_n  = bus.ext_lock;
        state_n = bus.ext_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        pend_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port is driven only during a grant cycle, straight from the owner's held inputs.
  assign in_gnt = (state == GNT_CPU) || (state == GNT_EXT);
  assign cur    = (state == GNT_EXT) ? {bus.ext_we, bus.ext_addr, bus.ext_wdata}
                                     : {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};

  assign bus.ram_en   = in_gnt;
  assign bus.ram_we   = in_gnt & cur.we;
  assign bus.ram_addr = in_gnt ? cur.addr  : '0;
  assign bus.ram_din  = in_gnt ? cur.wdata : '0;

  assign bus.cpu_gnt  = (state == GNT_CPU);
  assign bus.ext_gnt  = (state == GNT_EXT);

  assign rd_done        = (state == RD_WAIT) & pend;
  assign bus.cpu_rvalid = rd_done & ~owner;
  assign bus.ext_rvalid = rd_done & owner;
  assign bus.rdata      = (state == RD_WAIT) ? bus.ram_dout : '0;

  assign bus.cpu_stall  = bus.cpu_req & ~(bus.cpu_gnt & bus.cpu_we) & ~bus.cpu_rvalid;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 256x32 synchronous RAM.
// Contention expectations follow DRAM_ARB_RR_EN when it is defined for the build.
module tb_dram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dram_arbiter_if #(.AW(8), .DW(32)) bus ();

  dram_arbiter #(.AW(8), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h44; bus.cpu_wdata = 32'h1111_2222;
    repeat (2) tick();
    checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", {bus.cpu_gnt, bus.ext_gnt}); end
    checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {bus.cpu_rvalid, bus.ext_rvalid}); end
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b00) begin errors++; $display("FAIL reset_ram_en_we got %b want 00", {bus.ram_en, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 8'h00 || bus.ram_din !== 32'h0) begin errors++; $display("FAIL reset_ram_addr_din got %h/%h want 00/00000000", bus.ram_addr, bus.ram_din); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 00000000", bus.rdata); end
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", bus.cpu_stall); end
    bus.cpu_req = 1'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", bus.cpu_stall); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.cpu_stall !== 1'b1 || bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL wr_pending stall/gnt got %b%b want 10", bus.cpu_stall, bus.cpu_gnt); end
    tick();
    checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b want 1", bus.cpu_gnt); end
    checks++; if ({bus.ram_en, bus.ram_we} !== 2'b11) begin errors++; $display("FAIL wr_ram_en_we got %b want 11", {bus.ram_en, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 8'h10 || bus.ram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram_addr_din got %h/%h want 10/deadbeef", bus.ram_addr, bus.ram_din); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall got %b want 0", bus.cpu_stall); end
    tick();
    bus.cpu_req = 1'b0;
    checks++; if (bus.cpu_gnt !== 1'b0 || bus.ram_en !== 1'b0) begin errors++; $display("FAIL wr_idle gnt/en got %b%b want 00", bus.cpu_gnt, bus.ram_en); end
  endtask

  task automatic test_cpu_read;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    tick();
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_gnt gnt/we/stall got %b%b%b want 101", bus.cpu_gnt, bus.ram_we, bus.cpu_stall); end
    tick();
    checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_rvalid got %b want 10", {bus.cpu_rvalid, bus.ext_rvalid}); end
    checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", bus.rdata); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall got %b want 0", bus.cpu_stall); end
    tick();
    bus.cpu_req = 1'b0;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rd_after rvalid/rdata got %b/%h want 0/0", bus.cpu_rvalid, bus.rdata); end
  endtask

  task automatic test_contention;
    logic [1:0] exp;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 8'h10; bus.ext_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DRAM_ARB_RR_EN
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp = 2'b10;
`endif
      tick();
      checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== exp) begin errors++; $display("FAIL contend_gnt[%0d] got %b want %b", i, {bus.cpu_gnt, bus.ext_gnt}, exp); end
      tick();
      checks++; if ({bus.cpu_rvalid, bus.ext_rvalid} !== exp || bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL contend_rvalid[%0d] got %b/%h want %b/deadbeef", i, {bus.cpu_rvalid, bus.ext_rvalid}, bus.rdata, exp); end
      tick();
    end
    bus.cpu_req = 1'b0; bus.ext_req = 1'b0;
  endtask

  task automatic test_lock;
    int n;
    for (int k = 0; k < 4; k++) begin
      bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_lock = 1'b1;
      bus.ext_addr = 8'(k); bus.ext_wdata = 32'hA0 + 32'(k);
      tick();
      checks++; if ({bus.cpu_gnt, bus.ext_gnt} !== 2'b01) begin errors++; $display("FAIL lock_gnt[%0d] got %b want 01", k, {bus.cpu_gnt, bus.ext_gnt}); end
      checks++; if (bus.ram_addr !== 8'(k) || bus.ram_din !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL lock_ram[%0d] got %h/%h want %h/%h", k, bus.ram_addr, bus.ram_din, 8'(k), 32'hA0 + 32'(k)); end
      if (k == 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 32'h1234_5678;
      end
      tick();
      checks++; if (bus.cpu_gnt !== 1'b0 || bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL lock_idle[%0d] gnt/stall got %b%b want 01", k, bus.cpu_gnt, bus.cpu_stall); end
    end
    bus.ext_req = 1'b0; bus.ext_lock = 1'b0;
    n = 0;
    while (bus.cpu_gnt !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL lock_release cpu_gnt timeout got %b want 1", bus.cpu_gnt); end
    checks++; if (bus.ram_addr !== 8'h20 || bus.ram_din !== 32'h1234_5678) begin errors++; $display("FAIL lock_release_ram got %h/%h want 20/12345678", bus.ram_addr, bus.ram_din); end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int n;
    logic seen;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 8'h03; bus.ext_lock = 1'b0;
    tick();
    checks++; if (bus.ext_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h03) begin errors++; $display("FAIL mid_gnt gnt/we/addr got %b%b/%h want 10/03", bus.ext_gnt, bus.ram_we, bus.ram_addr); end
    tick();
    reset = 1'b0; bus.ext_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 32'h55AA_55AA;
    #1;
    checks++; if (bus.ext_rvalid !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL mid_rst rvalid/rdata got %b/%h want 0/0", bus.ext_rvalid, bus.rdata); end
    checks++; if ({bus.ram_en, bus.cpu_gnt, bus.ext_gnt} !== 3'b000 || bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL mid_rst en/gnt/stall got %b/%b want 000/1", {bus.ram_en, bus.cpu_gnt, bus.ext_gnt}, bus.cpu_stall); end
    tick();
    checks++; if ({bus.ext_rvalid, bus.cpu_gnt} !== 2'b00) begin errors++; $display("FAIL mid_rst_hold got %b want 00", {bus.ext_rvalid, bus.cpu_gnt}); end
    reset = 1'b1;
    seen = 1'b0;
    n = 0;
    while (bus.cpu_gnt !== 1'b1 && n < 4) begin
      tick();
      seen = seen | bus.ext_rvalid;
      n++;
    end
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 8'h30) begin errors++; $display("FAIL mid_release gnt/addr got %b/%h want 1/30", bus.cpu_gnt, bus.ram_addr); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_late_rvalid got %b want 0", seen); end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_addr_ff;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'hFF; bus.cpu_wdata = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 8'hFF || bus.ram_din !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ff_wr gnt/addr/din got %b/%h/%h want 1/ff/ffffffff", bus.cpu_gnt, bus.ram_addr, bus.ram_din); end
    tick();
    bus.cpu_we = 1'b0;
    tick();
    checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 8'hFF || bus.ram_we !== 1'b0) begin errors++; $display("FAIL ff_rd_gnt gnt/addr/we got %b/%h/%b want 1/ff/0", bus.cpu_gnt, bus.ram_addr, bus.ram_we); end
    tick();
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ff_rd rvalid/rdata got %b/%h want 1/ffffffff", bus.cpu_rvalid, bus.rdata); end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.ext_lock = 1'b0;
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_contention();
    test_lock();
    test_reset_mid_read();
    test_addr_ff();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
